btn_debouncer: RTL and testbench
================================

BTN_DEBOUNCER -- requirements
Module: btn_debouncer

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the number of consecutive stable synchronized samples needed to accept a press or release; the legal minimum is 2.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 btn_0_in..btn_3_in  input  1 each  raw, asynchronous, bouncy push-button levels; 1 = pressed.
REQ-005 btn_0_out..btn_3_out  output  1 each  one-clock press pulse per accepted press; directly drives the pulse-counter btn_N_in ports.
REQ-006 btn_0_lvl..btn_3_lvl  output  1 each  debounced button level.

Function
REQ-007 Each channel SHALL pass btn_N_in through a 2-flop synchronizer; "s" below denotes the second flop's output.
REQ-008 Each channel SHALL run an independent FSM with states IDLE, DEB_PRESS, PRESSED, DEB_RELEASE and a counter of $clog2(STABLE_CYCLES) bits.
REQ-009 IDLE: if s=1, go to DEB_PRESS with cnt<=0; otherwise stay.
REQ-010 DEB_PRESS: if s=0, go to IDLE; if cnt==STABLE_CYCLES-1, go to PRESSED; otherwise cnt<=cnt+1.
REQ-011 PRESSED: if s=0, go to DEB_RELEASE with cnt<=0; otherwise stay.
REQ-012 DEB_RELEASE: if s=1, go to PRESSED with no pulse; if cnt==STABLE_CYCLES-1, go to IDLE; otherwise cnt<=cnt+1.
REQ-013 btn_N_out SHALL be registered and high for exactly one cycle: the cycle following the DEB_PRESS->PRESSED transition.
REQ-014 btn_N_lvl SHALL be registered and high while the state is PRESSED or DEB_RELEASE.
REQ-015 Latency: if btn_N_in is sampled high first at edge E and stays high, btn_N_out SHALL rise at edge E+STABLE_CYCLES+2.
REQ-016 A raw high lasting at most STABLE_CYCLES cycles SHALL produce no pulse.
REQ-017 A raw high lasting at least STABLE_CYCLES+1 cycles SHALL produce exactly one pulse.
REQ-018 A held button SHALL produce exactly one pulse, regardless of hold length.
REQ-019 Release bounce (DEB_RELEASE returning to PRESSED) SHALL produce no pulse.
REQ-020 Channels SHALL be fully independent; simultaneous presses SHALL yield pulses in the same cycle on all affected channels.
REQ-021 The counter SHALL never exceed STABLE_CYCLES-1; no wrap-around is reachable.

Reset
REQ-022 While rst=0, all synchronizer flops, states (IDLE), counters, btn_N_out and btn_N_lvl SHALL be 0, taking effect immediately without waiting for a clock edge.
REQ-023 Reset asserted mid-debounce SHALL abort the press; no pulse is emitted for it.
REQ-024 A button held through reset release SHALL be treated as a new press and pulse once per REQ-015, with E being the first edge after deassertion.

Structure
REQ-025 The state encoding (2-bit constants ST_IDLE=0, ST_DEB_PRESS=1, ST_PRESSED=2, ST_DEB_RELEASE=3) SHALL reside in a shared package/include, btn_debouncer_pkg.
REQ-026 One sub-module, debounce_channel (synchronizer, FSM, counter, pulse/level registers), SHALL be instantiated four times by btn_debouncer.
REQ-027 The top level SHALL contain no logic beyond the instances and wiring.

Verification (STABLE_CYCLES=4, T=10 ns)
REQ-028 Clean press: btn_0_in high for 12 cycles from edge E -> btn_0_out high only in the cycle after edge E+6; btn_0_lvl high from E+6.
REQ-029 Bounce: btn_1_in toggles 1,0,1,0,1 for one cycle each, then stays high 10 cycles -> exactly one btn_1_out pulse; other outputs stay 0.
REQ-030 Glitch boundary: btn_2_in high for 4 cycles -> no pulse; then high for 5 cycles -> exactly one pulse.
REQ-031 Release bounce: btn_3_in held, released with 1-cycle high spikes, then low 10 cycles -> one pulse total; btn_3_lvl falls 6 edges after the final low sample.
REQ-032 Simultaneous presses and reset: all four inputs rise together -> four pulses in the same cycle; rst driven low during DEB_PRESS -> all outputs 0 at once and no pulse.
REQ-033 End-to-end: 16 bounced presses on btn_0_in with pulse_adder attached downstream -> count_0_out returns to 0 after wrap, and the other counts stay 0.

Source files
------------

// File: rtl/btn_debouncer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debouncer_pkg
//  Description : Shared state encoding and defaults for the button debouncer.
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_debouncer_pkg;

    localparam int c_DEF_STABLE_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } state_t;

    // The debounced level stays asserted while a release is still being qualified.
    function automatic logic is_level_state(input state_t st);
        return (st == ST_PRESSED) || (st == ST_DEB_RELEASE);
    endfunction

endpackage : btn_debouncer_pkg
`default_nettype wire

// File: rtl/btn_debouncer_if.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debouncer_if
//  Description : Raw button inputs plus pulse and level outputs of the debouncer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface btn_debouncer_if;

    logic btn_0_in;
    logic btn_1_in;
    logic btn_2_in;
    logic btn_3_in;

    logic btn_0_out;
    logic btn_1_out;
    logic btn_2_out;
    logic btn_3_out;

    logic btn_0_lvl;
    logic btn_1_lvl;
    logic btn_2_lvl;
    logic btn_3_lvl;

    modport master (
        output btn_0_in, btn_1_in, btn_2_in, btn_3_in,
        input  btn_0_out, btn_1_out, btn_2_out, btn_3_out,
        input  btn_0_lvl, btn_1_lvl, btn_2_lvl, btn_3_lvl
    );

    modport slave (
        input  btn_0_in, btn_1_in, btn_2_in, btn_3_in,
        output btn_0_out, btn_1_out, btn_2_out, btn_3_out,
        output btn_0_lvl, btn_1_lvl, btn_2_lvl, btn_3_lvl
    );

endinterface : btn_debouncer_if
`default_nettype wire

// File: rtl/btn_debouncer_debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One button: 2-flop synchronizer, debounce FSM, pulse/level regs.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import btn_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = c_DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_out,
    output logic btn_lvl
);

    localparam int                 c_CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic               r_sync1;
    logic               r_sync2;
    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_out;
    logic               r_lvl;

    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_pulse_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_lvl   <= 1'b0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_pulse_nxt;
            r_lvl   <= is_level_state(w_state_nxt);
        end
    end

    // A drop of the synchronized input always wins over the count reaching its limit.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = ST_DEB_PRESS;
                    w_cnt_nxt   = '0;
                end
            end
            ST_DEB_PRESS: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt = ST_PRESSED;
                    w_pulse_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_DEB_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_DEB_RELEASE: begin
                if (r_sync2) begin
                    w_state_nxt = ST_PRESSED;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign btn_out = r_out;
    assign btn_lvl = r_lvl;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/btn_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debouncer
//  Description : Four independent debounced push-button channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debouncer
    import btn_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = c_DEF_STABLE_CYCLES
) (
    input  logic           clk,
    input  logic           rst,
    btn_debouncer_if.slave bus
);

    debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_ch0 (
        .clk     (clk),
        .rst     (rst),
        .btn_in  (bus.btn_0_in),
        .btn_out (bus.btn_0_out),
        .btn_lvl (bus.btn_0_lvl)
    );

    debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_ch1 (
        .clk     (clk),
        .rst     (rst),
        .btn_in  (bus.btn_1_in),
        .btn_out (bus.btn_1_out),
        .btn_lvl (bus.btn_1_lvl)
    );

    debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_ch2 (
        .clk     (clk),
        .rst     (rst),
        .btn_in  (bus.btn_2_in),
        .btn_out (bus.btn_2_out),
        .btn_lvl (bus.btn_2_lvl)
    );

    debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_ch3 (
        .clk     (clk),
        .rst     (rst),
        .btn_in  (bus.btn_3_in),
        .btn_out (bus.btn_3_out),
        .btn_lvl (bus.btn_3_lvl)
    );

endmodule : btn_debouncer
`default_nettype wire

// File: tb/tb_btn_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_debouncer
//  Description : Scoreboard bench for btn_debouncer with STABLE_CYCLES = 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_debouncer;

    typedef struct {
        int mask;
        int edge_no;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_pass;
    exp_t exp_q[$];

    btn_debouncer_if bus();

    btn_debouncer #(.STABLE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge k is the k-th rising edge; at the following falling edge cyc == k.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int out_vec();
        return {28'd0, bus.btn_3_out, bus.btn_2_out, bus.btn_1_out, bus.btn_0_out};
    endfunction

    function automatic int lvl_vec();
        return {28'd0, bus.btn_3_lvl, bus.btn_2_lvl, bus.btn_1_lvl, bus.btn_0_lvl};
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    task automatic push(input int mask, input int edge_no);
        exp_t e;
        e.mask    = mask;
        e.edge_no = edge_no;
        exp_q.push_back(e);
    endtask

    task automatic set_in(input int ch, input logic v);
        case (ch)
            0:       bus.btn_0_in = v;
            1:       bus.btn_1_in = v;
            2:       bus.btn_2_in = v;
            default: bus.btn_3_in = v;
        endcase
    endtask

    task automatic set_all(input logic v);
        for (int c = 0; c < 4; c++) set_in(c, v);
    endtask

    // Bit i of bits is sampled by the DUT at the (i+1)-th rising edge after the call.
    task automatic drive_bits(input int ch, input int len, input logic [31:0] bits);
        for (int i = 0; i < len; i++) begin
            set_in(ch, bits[i]);
            @(negedge clk);
        end
    endtask

    // Monitor: every pulse cycle must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (out_vec() != 0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", out_vec(), 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_mask", out_vec(), e.mask);
                check("pulse_edge", cyc, e.edge_no);
            end
        end
    end

    initial begin
        int e;
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        set_all(1'b0);
        repeat (2) @(negedge clk);
        check("reset_out", out_vec(), 0);
        check("reset_lvl", lvl_vec(), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press on channel 0, held 12 cycles.
        e = cyc + 1;
        push(1, e + 6);
        set_in(0, 1'b1);
        repeat (6) @(negedge clk);
        check("ch0_lvl_before", lvl_vec(), 0);
        @(negedge clk);
        check("ch0_lvl_after", lvl_vec(), 1);
        repeat (5) @(negedge clk);
        set_in(0, 1'b0);
        repeat (10) @(negedge clk);

        // Bounced press on channel 1: 1,0,1,0 then high for 11 samples.
        e = cyc + 1;
        push(2, e + 10);
        drive_bits(1, 15, 32'h0000_7FF5);
        check("ch1_lvl_held", lvl_vec(), 2);
        set_in(1, 1'b0);
        repeat (10) @(negedge clk);

        // Glitch boundary on channel 2: 4 high samples rejected, 5 accepted.
        drive_bits(2, 4, 32'h0000_000F);
        set_in(2, 1'b0);
        repeat (10) @(negedge clk);
        e = cyc + 1;
        push(4, e + 6);
        drive_bits(2, 5, 32'h0000_001F);
        set_in(2, 1'b0);
        repeat (12) @(negedge clk);

        // Release bounce on channel 3: held 10, then 0,1,0,1, then low.
        e = cyc + 1;
        push(8, e + 6);
        drive_bits(3, 14, 32'h0000_2BFF);
        set_in(3, 1'b0);
        repeat (6) @(negedge clk);
        check("ch3_lvl_hold", int'(bus.btn_3_lvl), 1);
        @(negedge clk);
        check("ch3_lvl_fall", int'(bus.btn_3_lvl), 0);
        repeat (4) @(negedge clk);

        // Simultaneous press on all channels.
        e = cyc + 1;
        push(15, e + 6);
        set_all(1'b1);
        repeat (8) @(negedge clk);
        check("all_lvl_pressed", lvl_vec(), 15);

        // Asynchronous reset while pressed clears outputs without a clock edge.
        #2 rst = 1'b0;
        #1;
        check("async_rst_out", out_vec(), 0);
        check("async_rst_lvl", lvl_vec(), 0);

        // Buttons held through reset release count as a fresh press.
        @(negedge clk);
        rst = 1'b1;
        e = cyc + 1;
        push(15, e + 6);
        repeat (8) @(negedge clk);
        check("held_rst_lvl", lvl_vec(), 15);

        // Reset during DEB_PRESS aborts the press.
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_out", out_vec(), 0);
        check("abort_lvl", lvl_vec(), 0);
        set_all(1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_lvl_after", lvl_vec(), 0);

        // Sixteen bounced presses on channel 0, one pulse each.
        for (int k = 0; k < 16; k++) begin
            e = cyc + 1;
            push(1, e + 10);
            drive_bits(0, 15, 32'h0000_7FF5);
            set_in(0, 1'b0);
            repeat (10) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        check("pending_pulses", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_btn_debouncer
`default_nettype wire
